// File: rtl/prog_loader_if.sv
// prog_loader_if: host control, word stream, BRAM write ports and status of the loader
interface prog_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = ADDR_WIDTH - 1
);
  logic                  start;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  d_count;
  logic [CNT_WIDTH-1:0]  i_count;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] d_w_addr;
  logic [DATA_WIDTH-1:0] d_w_dat;
  logic                  d_w_enb;
  logic [ADDR_WIDTH-1:0] i_w_addr;
  logic [DATA_WIDTH-1:0] i_w_dat;
  logic                  i_w_enb;
  logic                  pc_stall;
  logic                  mem_rd_enb;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  modport master (
    output start, abort, d_count, i_count, s_valid, s_data,
    input  s_ready, d_w_addr, d_w_dat, d_w_enb, i_w_addr, i_w_dat, i_w_enb,
           pc_stall, mem_rd_enb, busy, done, err, err_code
  );
  modport slave (
    input  start, abort, d_count, i_count, s_valid, s_data,
    output s_ready, d_w_addr, d_w_dat, d_w_enb, i_w_addr, i_w_dat, i_w_enb,
           pc_stall, mem_rd_enb, busy, done, err, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams data then instruction words into BRAMs, verifies checksum, releases core
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = ADDR_WIDTH - 1
) (
  input logic clk,
  input logic rst,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_D, LOAD_I, CHECK, RUN, ERROR} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(2 ** (ADDR_WIDTH - 2));
  state_t state;
  logic [CNT_WIDTH-1:0] idx, d_cnt, i_cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic xfer, last, bad_cnt;
  assign bus.busy       = state inside {LOAD_D, LOAD_I, CHECK};
  assign bus.s_ready    = bus.busy;
  assign bus.done       = state == RUN;
  assign bus.err        = state == ERROR;
  assign bus.pc_stall   = state != RUN;
  assign bus.mem_rd_enb = state == RUN;
  assign xfer    = bus.s_valid && bus.s_ready;
  assign w_addr  = {idx[CNT_WIDTH-2:0], 2'b00};
  assign last    = idx == (state == LOAD_D ? d_cnt : i_cnt) - CNT_WIDTH'(1);
  assign bad_cnt = bus.i_count == '0 || bus.d_count > MAX_WORDS || bus.i_count > MAX_WORDS;
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state        <= IDLE;
      idx          <= '0;
      d_cnt        <= '0;
      i_cnt        <= '0;
      acc          <= '0;
      bus.err_code <= '0;
      bus.d_w_enb  <= 1'b0;
      bus.i_w_enb  <= 1'b0;
      bus.d_w_addr <= '0;
      bus.i_w_addr <= '0;
      bus.d_w_dat  <= '0;
      bus.i_w_dat  <= '0;
    end else begin
      bus.d_w_enb <= xfer && state == LOAD_D;
      bus.i_w_enb <= xfer && state == LOAD_I;
      if (xfer && state == LOAD_D) begin
        bus.d_w_addr <= w_addr;
        bus.d_w_dat  <= bus.s_data;
      end
      if (xfer && state == LOAD_I) begin
        bus.i_w_addr <= w_addr;
        bus.i_w_dat  <= bus.s_data;
      end
      if (xfer && state != CHECK) acc <= acc + bus.s_data;
      case (state)
        IDLE: if (bus.start) begin
          d_cnt        <= bus.d_count;
          i_cnt        <= bus.i_count;
          idx          <= '0;
          acc          <= '0;
          bus.err_code <= bad_cnt ? 2'd1 : 2'd0;
          state        <= bad_cnt ? ERROR : bus.d_count == '0 ? LOAD_I : LOAD_D;
        end
        LOAD_D: if (xfer) begin
          idx   <= last ? '0 : idx + CNT_WIDTH'(1);
          state <= last ? LOAD_I : LOAD_D;
        end
        LOAD_I: if (xfer) begin
          idx   <= last ? '0 : idx + CNT_WIDTH'(1);
          state <= last ? CHECK : LOAD_I;
        end
        CHECK: if (xfer) begin
          bus.err_code <= bus.s_data == acc ? 2'd0 : 2'd2;
          state        <= bus.s_data == acc ? RUN : ERROR;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synchronous program/data loader for the rv32i_sc core.
- Replaces bench-driven BRAM initialisation with an FSM. The FSM accepts a valid/ready word stream and writes `d_count` words into data BRAM, then `i_count` words into instruction BRAM.
- Checks a trailing checksum word, then releases the core (PC stall off, read enables on).
- Sits between a host link (UART/DMA bridge) and the write ports of both bram32 instances. It owns the BRAM write ports until the core is released.

Parameters:
- DATA_WIDTH, 32, stream word and BRAM data width.
- ADDR_WIDTH, 10, BRAM byte-address width; max words per memory = 2^(ADDR_WIDTH-2).
- CNT_WIDTH, ADDR_WIDTH-1, width of count inputs; must hold 2^(ADDR_WIDTH-2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches counts; honoured only in IDLE
- abort  in  1  returns FSM to IDLE from any state; highest priority after rst
- d_count  in  CNT_WIDTH  data words to load (0 allowed)
- i_count  in  CNT_WIDTH  instruction words to load (must be >0)
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream word
- s_ready  out  1  loader accepts word
- d_w_addr  out  ADDR_WIDTH  data BRAM byte address
- d_w_dat  out  DATA_WIDTH  data BRAM write data
- d_w_enb  out  1  data BRAM write enable
- i_w_addr  out  ADDR_WIDTH  instruction BRAM byte address
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data
- i_w_enb  out  1  instruction BRAM write enable
- pc_stall  out  1  PC stall to core
- mem_rd_enb  out  1  drives register-file read enable and instruction BRAM r_enb
- busy  out  1  high in LOAD_D, LOAD_I, CHECK
- done  out  1  high in RUN
- err  out  1  high in ERROR
- err_code  out  2  0 none, 1 bad count, 2 checksum mismatch

Behaviour:
- Reset: state=IDLE.
  - All w_enb/addr/dat = 0, s_ready=0.
  - pc_stall=1, mem_rd_enb=0, busy=done=err=0, err_code=0.
  - Word index and checksum accumulator = 0.
- Priority: rst > abort > start/stream.
- abort: same output values as reset, except it is a cycle-clocked event. Pending write enables are dropped and no write occurs in the cycle after abort.
- States: IDLE, LOAD_D, LOAD_I, CHECK, RUN, ERROR.
- IDLE + start:
  - If i_count==0, or either count > 2^(ADDR_WIDTH-2): go to ERROR, err_code=1.
  - Else if d_count==0: go to LOAD_I.
  - Else: go to LOAD_D.
  - Counts are latched in all cases; later changes on the count inputs are ignored.
- Handshake:
  - s_ready = 1 in LOAD_D, LOAD_I, CHECK; 0 otherwise.
  - Transfer occurs when s_valid && s_ready.
  - s_valid may drop at any time; gaps stall progress with no side effects.
- Write timing (registered): a word transferred in cycle N produces w_enb=1 in cycle N+1 only, with w_addr = index*4 and w_dat = the word.
  - Back-to-back transfers give continuous enables.
  - w_addr and w_dat hold their last value when w_enb=0.
- Index: resets to 0 on entry to LOAD_D and on entry to LOAD_I.
  - The last data word moves the FSM to LOAD_I; the next word is instruction 0.
  - The last instruction word moves the FSM to CHECK.
- Checksum: accumulator = sum modulo 2^DATA_WIDTH of all data and instruction words, in arrival order.
  - In CHECK, one word is accepted.
  - If it equals the accumulator: go to RUN.
  - Otherwise: go to ERROR, err_code=2.
- Release: the final instruction write completes (cycle after last transfer) before CHECK can complete, so the core never runs on a partially written BRAM.
- RUN: pc_stall=0, mem_rd_enb=1, done=1; all w_enb=0; start is ignored.
  - The core and its control logic own data-BRAM writes via an external mux selected by `done`.
- ERROR: pc_stall=1, err=1, err_code held. Exit only via rst or abort.
- Reset or abort mid-load: BRAM contents are left as partially written. The next start restarts from index 0.

Test Plan:
- Normal load: d_count=3 with data 1,3,5; i_count=7; checksum word correct → d_w_enb pulses at addresses 0x0, 0x4, 0x8; i_w_enb pulses at 0x0…0x18; RUN reached 1 cycle after the checksum transfer; pc_stall falls and done=1.
- Checksum mismatch: same stream with checksum+1 → all 10 writes occur; state goes to ERROR with err=1, err_code=2; pc_stall remains 1.
- Bad count: start with i_count=0 → next cycle err=1, err_code=1, s_ready never asserts. Separately, start with d_count=257 (ADDR_WIDTH=10) → err_code=1.
- Backpressure/gaps: toggle s_valid randomly across the normal load → write addresses stay strictly sequential; no enable without a preceding transfer; final memory image identical to the no-gap case.
- d_count=0: i_count=2, words A,B, checksum A+B → d_w_enb never asserts; i_w_enb at 0x0 and 0x4; RUN reached.
- Abort/reset mid-load: abort after 2 data transfers → next cycle state is IDLE, busy=0, no further enables. Then rst mid-LOAD_I → all outputs at reset values; a subsequent full load completes normally.
